shift_issue_stage: RTL
======================

// Module: shift_issue_stage
// PURPOSE
//  Decode-to-execute issue stage for shift/rotate instructions. Decodes WISC shift opcodes into
//  right-only shifter controls (operand, 4-bit count, op) and buffers them in a 2-entry
//  valid/ready skid buffer. Sits directly upstream of the barrel shifter, between decode and EX.
//  Left shifts/rotates are mapped onto the right-only shifter here.
// PARAMETERS
//  N       16  datapath / operand width
//  C       4   shift-count width (log2 N)
//  PERF_W  16  width of the optional stall counter
// PORTS
//  clk            in   1  system clock, all state on rising edge
//  rst            in   1  synchronous, active-high reset
//  flush          in   1  squash all buffered entries (branch mispredict)
//  in_valid       in   1  decode presents an instruction
//  in_ready       out  1  stage can accept (registered)
//  in_instr       in   16 instruction word
//  in_rs          in   N  source operand (value to be shifted)
//  in_rt          in   N  register-form count source, bits [C-1:0] used
//  out_valid      out  1  entry presented to EX
//  out_ready      in   1  EX consumes entry
//  out_in         out  N  shifter operand (bit-reversed when out_rev=1)
//  out_cnt        out  C  shifter count
//  out_op         out  1  1 = logical right shift, 0 = rotate right
//  out_rev        out  1  EX must bit-reverse shifter result (SLL/SLLI)
//  out_is_shift   out  1  entry is a shift/rotate instruction
//  out_rd         out  3  destination register
//  perf_stall_cnt out  PERF_W  stall counter (only with SHIFT_ISSUE_PERF_EN)
// BEHAVIOUR
//  Decode (op=instr[15:11]): 10100 ROLI, 10101 SLLI, 10110 RORI, 10111 SRLI -> count=instr[3:0],
//   rd=instr[7:5]. 11010 register form, funct=instr[1:0]: 00 ROL, 01 SLL, 10 ROR, 11 SRL ->
//   count=in_rt[3:0], rd=instr[4:2]. Other opcodes: is_shift=0, out_in=in_rs, cnt=0, op=0, rev=0,
//   rd=instr[10:8].
//  Mapping, n=count: RORx -> op=0,cnt=n. SRLx -> op=1,cnt=n. ROLx -> op=0,cnt=(16-n) mod 16
//   (n=0 gives 0). SLLx -> op=1,cnt=n,rev=1, out_in=bitreverse(in_rs). Arithmetic is C bits, wraps.
//  Buffer: main register M drives outputs; skid register S. Accept = in_valid & in_ready.
//   M empty or (out_valid & out_ready): accepted entry (or S if full) loads M; S drains first, FIFO order.
//   M held (out_valid & ~out_ready) and accept: entry goes to S.
//   in_ready(next) = ~S_full(next). Latency in->out: 1 cycle; full throughput when out_ready=1.
//  Outputs stable while out_valid & ~out_ready (no change until handshake).
//  flush: next cycle M and S empty, out_valid=0, in_ready=1; entry accepted in the flush cycle
//   is dropped. flush wins over all simultaneous events.
//  rst: same as flush plus all data outputs = 0, perf counter = 0. Reset mid-transfer drops entries.
//  Reset values: in_ready=1, out_valid=0, out_in=0, out_cnt=0, out_op=0, out_rev=0,
//   out_is_shift=0, out_rd=0.
// CONFIGURATION
//  SHIFT_ISSUE_PERF_EN defined: perf_stall_cnt increments each cycle out_valid & ~out_ready,
//   saturates at 2^PERF_W-1, cleared by rst only (not flush).
//  Not defined: perf_stall_cnt port and counter absent; no other behaviour changes.
// TESTING
//  1. RORI instr=16'hB003, rs=16'h8001, out_ready=1 -> next cycle out_valid=1, out_in=8001,
//     cnt=3, op=0, rev=0, rd=0.
//  2. ROL reg form instr=16'hD000 (funct 00), rt=16'h0004 -> cnt=12, op=0; rt=0 -> cnt=0.
//  3. SLLI instr=16'hA801 (n=1), rs=16'h0001 -> out_in=16'h8000, cnt=1, op=1, rev=1.
//  4. out_ready=0, three back-to-back in_valid -> first in M, second in S, in_ready=0 next cycle,
//     third not accepted; release out_ready -> entries appear in order, in_ready returns to 1.
//  5. M and S full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1,
//     no accepted entry ever appears.
//  6. With SHIFT_ISSUE_PERF_EN: hold out_valid=1, out_ready=0 for 5 cycles -> perf_stall_cnt=5;
//     assert rst -> 0.

Source files
------------

// File: rtl/shift_issue_stage.sv
// Shift/rotate issue stage: decodes shift opcodes into right-only shifter controls and buffers
// them in a 2-entry skid buffer. Optional stall counter enabled by SHIFT_ISSUE_PERF_EN.
module shift_issue_stage #(
   parameter int unsigned N = 16,
   parameter int unsigned C = 4
`ifdef SHIFT_ISSUE_PERF_EN
   ,
   parameter int unsigned PERF_W = 16
`endif
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [15:0]   in_instr_i,
   input  logic [N-1:0]  in_rs_i,
   input  logic [N-1:0]  in_rt_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [N-1:0]  out_in_o,
   output logic [C-1:0]  out_cnt_o,
   output logic          out_op_o,
   output logic          out_rev_o,
   output logic          out_is_shift_o,
   output logic [2:0]    out_rd_o
`ifdef SHIFT_ISSUE_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_stall_cnt_o
`endif
);

   typedef struct packed {
      logic [N-1:0] din;
      logic [C-1:0] cnt;
      logic         op;
      logic         rev;
      logic         is_shift;
      logic [2:0]   rd;
   } entry_t;

   entry_t       dec;
   entry_t       m_d, m_q, s_d, s_q;
   logic         m_valid_d, m_valid_q, s_valid_d, s_valid_q;
   logic         in_ready_d, in_ready_q;
   logic         accept, pop;
   logic [4:0]   opc;
   logic [1:0]   kind;
   logic [C-1:0] n;
   logic [2:0]   rd;
   logic         is_sh;
   logic [N-1:0] rs_rev;
   logic         unused_rt;

   assign unused_rt = ^in_rt_i[N-1:C];
   assign opc       = in_instr_i[15:11];

   always_comb begin
      for (int i = 0; i < int'(N); i++) begin
         rs_rev[i] = in_rs_i[N-1-i];
      end
   end

   // kind encoding shared by both forms: 00 ROL, 01 SLL, 10 ROR, 11 SRL
   always_comb begin
      is_sh = 1'b0;
      kind  = 2'b00;
      n     = '0;
      rd    = in_instr_i[10:8];
      case (opc)
         5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
            is_sh = 1'b1;
            kind  = opc[1:0];
            n     = in_instr_i[C-1:0];
            rd    = in_instr_i[7:5];
         end
         5'b11010: begin
            is_sh = 1'b1;
            kind  = in_instr_i[1:0];
            n     = in_rt_i[C-1:0];
            rd    = in_instr_i[4:2];
         end
         default: ;
      endcase
   end

   always_comb begin
      dec          = '0;
      dec.din      = in_rs_i;
      dec.rd       = rd;
      dec.is_shift = is_sh;
      if (is_sh) begin
         unique case (kind)
            2'b00: dec.cnt = -n;
            2'b01: begin
               dec.op  = 1'b1;
               dec.cnt = n;
               dec.rev = 1'b1;
               dec.din = rs_rev;
            end
            2'b10: dec.cnt = n;
            2'b11: begin
               dec.op  = 1'b1;
               dec.cnt = n;
            end
         endcase
      end
   end

   assign accept = in_valid_i & in_ready_q;
   assign pop    = ~m_valid_q | out_ready_i;

   // M is empty only when S is empty, so S always drains into M first.
   always_comb begin
      m_d       = m_q;
      s_d       = s_q;
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;
      if (pop) begin
         if (s_valid_q) begin
            m_d       = s_q;
            m_valid_d = 1'b1;
            s_valid_d = 1'b0;
         end else begin
            m_valid_d = accept;
            if (accept) m_d = dec;
         end
      end else if (accept) begin
         s_d       = dec;
         s_valid_d = 1'b1;
      end
      if (flush_i) begin
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end
      in_ready_d = ~s_valid_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         m_q        <= '0;
         s_q        <= '0;
         m_valid_q  <= 1'b0;
         s_valid_q  <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         m_q        <= m_d;
         s_q        <= s_d;
         m_valid_q  <= m_valid_d;
         s_valid_q  <= s_valid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready_o     = in_ready_q;
   assign out_valid_o    = m_valid_q;
   assign out_in_o       = m_q.din;
   assign out_cnt_o      = m_q.cnt;
   assign out_op_o       = m_q.op;
   assign out_rev_o      = m_q.rev;
   assign out_is_shift_o = m_q.is_shift;
   assign out_rd_o       = m_q.rd;

`ifdef SHIFT_ISSUE_PERF_EN
   logic [PERF_W-1:0] perf_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_q <= '0;
      end else if (m_valid_q && !out_ready_i && !(&perf_q)) begin
         perf_q <= perf_q + PERF_W'(1);
      end
   end

   assign perf_stall_cnt_o = perf_q;
`endif

endmodule
